// File: rtl/chunked_adder_pkg.sv
// Shared types and constants for the chunked adder: FSM state encoding and
// add/subtract mode values.
package chunked_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunked_adder_if.sv
// Request/result bundle of the chunked adder. The master issues operations;
// the slave (the adder) returns the registered result and flags.
interface chunked_adder_if #(
   parameter int N = 8
);
   logic         start;
   logic         ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic [N-1:0] s;
   logic         cout;
   logic         ovf;
   logic         zero;
   logic         done;

   modport master (
      output start, a, b, cin, sub,
      input  ready, s, cout, ovf, zero, done
   );

   modport slave (
      input  start, a, b, cin, sub,
      output ready, s, cout, ovf, zero, done
   );
endinterface

// File: rtl/chunked_adder_slice.sv
// W-bit combinational slice adder. Also reports the carry into its MSB so the
// caller can derive signed overflow on the final slice.
module slice_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic         o_cmsb
);
   logic [W:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
   assign o_sum  = w_full[W-1:0];
   assign o_cout = w_full[W];
   // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out by XOR.
   assign o_cmsb = w_full[W-1] ^ i_a[W-1] ^ i_b[W-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle N-bit adder/subtractor that processes one W-bit slice per cycle,
// LSB first, and publishes the result and flags together with a done pulse.
module chunked_adder
   import chunked_adder_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   chunked_adder_if.slave bus
);
   localparam int C  = N / W;
   localparam int KW = (C > 1) ? $clog2(C) : 1;

   state_t          r_state;
   state_t          w_next;
   logic            w_ready;
   logic            w_last;
   logic [KW-1:0]   r_k;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_sum;
   logic            r_carry;
   logic            r_cmsb;
   logic [N-1:0]    r_s;
   logic            r_cout;
   logic            r_ovf;
   logic            r_zero;
   logic            r_done;
   logic [W-1:0]    w_sl_sum;
   logic            w_sl_cout;
   logic            w_sl_cmsb;
   logic [N-1:0]    w_a_shr;
   logic [N-1:0]    w_b_shr;
   logic [N-1:0]    w_sum_shin;

   slice_adder #(.W(W)) u_slice (
      .i_a    (r_a[W-1:0]),
      .i_b    (r_b[W-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sl_sum),
      .o_cout (w_sl_cout),
      .o_cmsb (w_sl_cmsb)
   );

   // Operands drain from the bottom; slice sums enter from the top.
   generate
      if (C == 1) begin : g_single
         assign w_a_shr    = '0;
         assign w_b_shr    = '0;
         assign w_sum_shin = w_sl_sum;
      end else begin : g_multi
         assign w_a_shr    = {{W{1'b0}}, r_a[N-1:W]};
         assign w_b_shr    = {{W{1'b0}}, r_b[N-1:W]};
         assign w_sum_shin = {w_sl_sum, r_sum[N-1:W]};
      end
   endgenerate

   assign w_last = (r_k == KW'(C - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.start) w_next = RUN;
         end
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_a     <= bus.a;
               r_b     <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
               r_carry <= (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
               r_cmsb  <= 1'b0;
               r_k     <= '0;
            end
            RUN: begin
               r_a     <= w_a_shr;
               r_b     <= w_b_shr;
               r_sum   <= w_sum_shin;
               r_carry <= w_sl_cout;
               r_cmsb  <= w_sl_cmsb;
               r_k     <= w_last ? '0 : r_k + 1'b1;
            end
            DONE: begin
               // r_cmsb / r_carry hold the carries into and out of bit N-1.
               r_s    <= r_sum;
               r_cout <= r_carry;
               r_ovf  <= r_carry ^ r_cmsb;
               r_zero <= (r_sum == '0);
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready = w_ready;
   assign bus.s     = r_s;
   assign bus.cout  = r_cout;
   assign bus.ovf   = r_ovf;
   assign bus.zero  = r_zero;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed table on N=8/W=4, abort and ignored-start
// sequences, and back-to-back random runs on N=8/W=8 and N=16/W=2.
module tb_chunked_adder;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   chunked_adder_if #(.N(8))  bus_a ();
   chunked_adder_if #(.N(8))  bus_b ();
   chunked_adder_if #(.N(16)) bus_c ();

   chunked_adder #(.N(8),  .W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   chunked_adder #(.N(8),  .W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   chunked_adder #(.N(16), .W(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       cout;
      logic       ovf;
      logic       zero;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic ok,
                        input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Reference: {ovf, zero, cout, s} computed with a wide adder.
   function automatic logic [18:0] model(input int n, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin,
                                         input logic sub);
      logic [16:0] mask, eb, full;
      logic [15:0] s;
      logic        c, ov;
      mask = (17'd1 << n) - 17'd1;
      eb   = sub ? ({1'b0, ~b} & mask) : ({1'b0, b} & mask);
      c    = sub ? 1'b1 : cin;
      full = {1'b0, a} + eb + {16'd0, c};
      s    = full[15:0] & mask[15:0];
      ov   = (a[n-1] == eb[n-1]) && (s[n-1] != a[n-1]);
      return {ov, (s == 16'd0), full[n], s};
   endfunction

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic op_a(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output int lat, output logic rdy);
      rdy = bus_a.ready;
      bus_a.a = a; bus_a.b = b; bus_a.cin = cin; bus_a.sub = sub; bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0; bus_a.a = ~a; bus_a.b = a ^ b; bus_a.cin = ~cin; bus_a.sub = ~sub;
      lat = 0;
      do begin @(posedge clk); lat++; @(negedge clk); end
      while (!bus_a.done && lat < 40);
   endtask

   task automatic op_b(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
      logic [18:0] e;
      logic        rdy;
      int          lat;
      rdy = bus_b.ready;
      bus_b.a = a; bus_b.b = b; bus_b.cin = cin; bus_b.sub = sub; bus_b.start = 1'b1;
      @(posedge clk); #1;
      bus_b.start = 1'b0; bus_b.a = ~a; bus_b.b = a ^ b; bus_b.cin = ~cin; bus_b.sub = ~sub;
      lat = 0;
      do begin @(posedge clk); lat++; @(negedge clk); end
      while (!bus_b.done && lat < 40);
      e = model(8, {8'd0, a}, {8'd0, b}, cin, sub);
      check("rand_n8w8",
            bus_b.done && rdy && lat == 2 && bus_b.s == e[7:0] && bus_b.cout == e[16]
            && bus_b.zero == e[17] && bus_b.ovf == e[18],
            {lat[7:0], 1'b0, bus_b.ovf, bus_b.zero, bus_b.cout, 4'd0, 8'd0, bus_b.s},
            {8'd2, 1'b0, e[18], e[17], e[16], 4'd0, 8'd0, e[7:0]});
   endtask

   task automatic op_c(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub);
      logic [18:0] e;
      logic        rdy;
      int          lat;
      rdy = bus_c.ready;
      bus_c.a = a; bus_c.b = b; bus_c.cin = cin; bus_c.sub = sub; bus_c.start = 1'b1;
      @(posedge clk); #1;
      bus_c.start = 1'b0; bus_c.a = ~a; bus_c.b = a ^ b; bus_c.cin = ~cin; bus_c.sub = ~sub;
      lat = 0;
      do begin @(posedge clk); lat++; @(negedge clk); end
      while (!bus_c.done && lat < 40);
      e = model(16, a, b, cin, sub);
      check("rand_n16w2",
            bus_c.done && rdy && lat == 9 && bus_c.s == e[15:0] && bus_c.cout == e[16]
            && bus_c.zero == e[17] && bus_c.ovf == e[18],
            {lat[7:0], 1'b0, bus_c.ovf, bus_c.zero, bus_c.cout, 4'd0, bus_c.s},
            {8'd9, 1'b0, e[18], e[17], e[16], 4'd0, e[15:0]});
   endtask

   initial begin
      int         lat, ndone;
      logic       rdy;
      logic [7:0] got_s;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.a = '0; bus_a.b = '0; bus_a.cin = 1'b0; bus_a.sub = 1'b0;
      bus_b.start = 1'b0; bus_b.a = '0; bus_b.b = '0; bus_b.cin = 1'b0; bus_b.sub = 1'b0;
      bus_c.start = 1'b0; bus_c.a = '0; bus_c.b = '0; bus_c.cin = 1'b0; bus_c.sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_state",
            bus_a.s == 8'h00 && !bus_a.cout && !bus_a.ovf && !bus_a.zero && !bus_a.done
            && bus_a.ready,
            {bus_a.ready, bus_a.done, bus_a.zero, bus_a.ovf, bus_a.cout, bus_a.s},
            {1'b1, 4'b0000, 8'h00});

      for (int i = 0; i < 10; i++) begin
         op_a(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, rdy);
         check($sformatf("vec%0d", i),
               bus_a.done && rdy && bus_a.s == vecs[i].s && bus_a.cout == vecs[i].cout
               && bus_a.ovf == vecs[i].ovf && bus_a.zero == vecs[i].zero,
               {bus_a.done, bus_a.ovf, bus_a.zero, bus_a.cout, bus_a.s},
               {1'b1, vecs[i].ovf, vecs[i].zero, vecs[i].cout, vecs[i].s});
         check($sformatf("vec%0d_latency", i), lat == 3, lat, 32'd3);
      end

      // Start pulsed during RUN/DONE with other operands must be dropped.
      bus_a.a = 8'h22; bus_a.b = 8'h11; bus_a.cin = 1'b0; bus_a.sub = 1'b0; bus_a.start = 1'b1;
      @(posedge clk);
      ndone = 0; got_s = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0)
            check("busy_hold", !bus_a.ready && bus_a.s == 8'hFF,
                  {bus_a.ready, bus_a.s}, {1'b0, 8'hFF});
         if (i < 3) begin
            bus_a.start = 1'b1; bus_a.a = 8'h99; bus_a.b = 8'h99;
         end else bus_a.start = 1'b0;
         if (bus_a.done) begin ndone++; got_s = bus_a.s; end
         @(posedge clk);
      end
      check("ignored_start_ndone", ndone == 1, ndone, 32'd1);
      check("ignored_start_result", got_s == 8'h33, got_s, 32'h33);

      // Abort mid-RUN; start coincident with rst is also dropped.
      @(negedge clk);
      bus_a.a = 8'h40; bus_a.b = 8'h02; bus_a.cin = 1'b0; bus_a.sub = 1'b0; bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; bus_a.start = 1'b0;
      check("abort_state",
            bus_a.s == 8'h00 && !bus_a.cout && !bus_a.ovf && !bus_a.zero && !bus_a.done
            && bus_a.ready,
            {bus_a.ready, bus_a.done, bus_a.zero, bus_a.ovf, bus_a.cout, bus_a.s},
            {1'b1, 4'b0000, 8'h00});
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_a.done) ndone++;
      end
      check("abort_no_done", ndone == 0, ndone, 32'd0);
      op_a(8'h21, 8'h21, 1'b0, 1'b0, lat, rdy);
      check("after_abort",
            bus_a.done && rdy && lat == 3 && bus_a.s == 8'h42 && !bus_a.cout && !bus_a.zero,
            {lat[7:0], bus_a.done, bus_a.cout, bus_a.zero, bus_a.s},
            {8'd3, 1'b1, 1'b0, 1'b0, 8'h42});

      for (int i = 0; i < 1000; i++)
         op_b(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 1000; i++)
         op_c(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL provide parameter N, default 8: operand and result width in bits.
REQ-002 SHALL provide parameter W, default 4: slice width added per cycle; N mod W == 0 and 1 <= W <= N are required.
REQ-003 SHALL provide derived constant C = N/W: number of slice cycles per operation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a new operation; accepted only when ready=1.
REQ-007 ready  output  1  block idle, can accept start.
REQ-008 a, b  input  N  operands, sampled only on the accepting edge.
REQ-009 cin  input  1  carry-in, sampled with a and b; ignored when sub=1.
REQ-010 sub  input  1  mode, sampled with a and b: 0 = a+b+cin, 1 = a-b.
REQ-011 s  output  N  registered result.
REQ-012 cout  output  1  registered carry-out; in subtract mode, 1 = no borrow.
REQ-013 ovf  output  1  registered two's-complement signed overflow.
REQ-014 zero  output  1  registered flag, 1 when s == 0.
REQ-015 done  output  1  one-cycle pulse marking that s and the flags have been updated.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE; ready SHALL be 1 only in IDLE.
REQ-017 IDLE with start=1 SHALL capture a, the effective operand (b when sub=0, ~b when sub=1) and the initial carry (cin when sub=0, 1 when sub=1), clear slice index k to 0, and go to RUN.
REQ-018 In RUN, each cycle SHALL add slice k of both operands plus the running carry, store the W-bit slice sum, register the carry-out, and increment k.
REQ-019 When k == C-1, RUN SHALL complete its final slice and go to DONE on the next edge.
REQ-020 On entry to DONE, the block SHALL update s, cout, ovf and zero together; ovf = (carry into bit N-1) XOR (carry out of bit N-1).
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be fixed: start accepted at edge t gives done=1 in the cycle following edge t+C+1.
REQ-023 start while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-024 Changes to a, b, cin or sub after acceptance SHALL NOT affect the operation in flight.
REQ-025 s and all flags SHALL hold their last values until the next done; they SHALL NOT change during RUN.
REQ-026 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one result per C+2 cycles.
REQ-027 W == N SHALL be legal: C = 1, a single RUN cycle.
REQ-028 Wrap-around: the result SHALL be modulo 2^N, with the lost carry reported only through cout.

Reset
REQ-029 rst=1 at an edge SHALL force state IDLE, k=0, s=0, cout=0, ovf=0, zero=0, done=0, and clear the internal operand and carry registers.
REQ-030 Reset during RUN or DONE SHALL abort the operation with no done pulse; ready=1 in the first cycle after rst is released.
REQ-031 start coincident with rst=1 SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration type (IDLE, RUN, DONE) and the mode encoding constants (MODE_ADD=0, MODE_SUB=1).
REQ-033 The per-cycle W-bit combinational slice SHALL be a sub-module named slice_adder, with ports for two W-bit slices, carry-in, W-bit sum, carry-out and carry into its MSB.
REQ-034 The operand registers SHALL right-shift by W each RUN cycle, and the sum SHALL be assembled by shift-in; no N-bit adder SHALL exist.

Verification
REQ-035 N=8, W=4: a=0xFF, b=0x01, cin=0, sub=0 -> s=0x00, cout=1, zero=1, ovf=0, done 3 cycles after acceptance.
REQ-036 N=8, W=4: a=0x7F, b=0x01, sub=0 -> s=0x80, cout=0, ovf=1, zero=0.
REQ-037 N=8, W=4: a=0x05, b=0x07, sub=1, cin=1 -> s=0xFE, cout=0, ovf=0 (cin ignored).
REQ-038 start pulsed again, with different operands, during RUN -> ignored; exactly one done, carrying the first operation's result.
REQ-039 rst=1 for 1 cycle mid-RUN -> no done, s=0, ready=1 after release; the next operation is correct.
REQ-040 N=8, W=8 and N=16, W=2: random operands, 1000 operations back-to-back -> every result matches the reference model, at latencies 2 and 9 respectively.
